// File: rtl/pwm_link_pkg.sv
// Shared definitions for the PWM link: FSM states, default frame timing and code width.
package pwm_link_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } pwm_state_e;

    localparam int PWM_PERIOD_DEF = 256;
    localparam int PWM_TOL_DEF    = 4;
    localparam int PWM_CODE_W     = 8;

endpackage

// File: rtl/pwm_duty_decoder_if.sv
// Decoded-duty result bus: code, strobe and link status flags.
interface pwm_duty_decoder_if;
    import pwm_link_pkg::*;

    logic [PWM_CODE_W-1:0] duty_out;
    logic                  duty_valid;
    logic                  period_err;
    logic                  locked;

    modport master (output duty_out, duty_valid, period_err, locked);
    modport slave  (input  duty_out, duty_valid, period_err, locked);

endinterface

// File: rtl/pwm_edge_sync.sv
// Brings the asynchronous PWM input into the CLOCK_50 domain and flags its rising edges.
module pwm_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLOCK_50,
    input  logic rst,
    input  logic pwm_in,
    output logic pwm_s,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   pwm_s_dly_q, pwm_s_dly_d;

    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], pwm_in};
        pwm_s_dly_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            sync_q      <= '0;
            pwm_s_dly_q <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            pwm_s_dly_q <= pwm_s_dly_d;
        end
    end

    assign pwm_s = sync_q[SYNC_STAGES-1];
    assign rise  = pwm_s & ~pwm_s_dly_q;

endmodule

// File: rtl/pwm_duty_decoder.sv
// PWM receive end: measures high time per frame and reports it as an 8-bit duty code.
// Optional build macro AVG_EN smooths reported codes with a 4-entry moving average.
module pwm_duty_decoder
    import pwm_link_pkg::*;
#(
    parameter int PERIOD      = PWM_PERIOD_DEF,
    parameter int TOL         = PWM_TOL_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic               CLOCK_50,
    input  logic               rst,
    input  logic               pwm_in,
    pwm_duty_decoder_if.master dec
);

    localparam int CNT_W = $clog2(2 * PERIOD);
    localparam logic [CNT_W-1:0] CNT_MAX      = CNT_W'(2 * PERIOD - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(PERIOD + TOL - 1);
    localparam logic [CNT_W:0]   LEN_MIN      = (CNT_W + 1)'(PERIOD - TOL);
    localparam logic [CNT_W:0]   LEN_MAX      = (CNT_W + 1)'(PERIOD + TOL);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    // Only one of the two shifts is non-zero for any power-of-2 PERIOD.
    function automatic logic [PWM_CODE_W-1:0] scale_code(input logic [CNT_W-1:0] cnt);
        int unsigned v;
        v = 32'(cnt);
        v = v >> $clog2(PERIOD / 256);
        v = v << $clog2(256 / PERIOD);
        if (v > 255) v = 255;
        return v[PWM_CODE_W-1:0];
    endfunction

    logic pwm_s, rise;

    pwm_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .CLOCK_50 (CLOCK_50),
        .rst      (rst),
        .pwm_in   (pwm_in),
        .pwm_s    (pwm_s),
        .rise     (rise)
    );

    pwm_state_e            state_q, state_d;
    logic [CNT_W-1:0]      period_cnt_q, period_cnt_d;
    logic [CNT_W-1:0]      high_cnt_q, high_cnt_d;
    logic [PWM_CODE_W-1:0] duty_q, duty_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;
    logic                  locked_q, locked_d;
    logic                  strobe;
    logic [PWM_CODE_W-1:0] new_code, out_code;
    logic [CNT_W:0]        frame_len;
    logic                  frame_ok;

    assign frame_len = {1'b0, period_cnt_q} + 1'b1;
    assign frame_ok  = (frame_len >= LEN_MIN) && (frame_len <= LEN_MAX);

    // A restart counts the current cycle as the first of the new frame, hence high_cnt seeds from pwm_s.
    always_comb begin
        state_d      = state_q;
        period_cnt_d = period_cnt_q;
        high_cnt_d   = high_cnt_q;
        err_d        = err_q;
        locked_d     = locked_q;
        strobe       = 1'b0;
        new_code     = '0;
        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d      = MEASURE;
                    period_cnt_d = '0;
                    high_cnt_d   = CNT_W'(pwm_s);
                end
            end
            MEASURE: begin
                if (rise) begin
                    if (frame_ok) begin
                        strobe   = 1'b1;
                        new_code = scale_code(high_cnt_q);
                        locked_d = 1'b1;
                        err_d    = 1'b0;
                    end else begin
                        err_d    = 1'b1;
                    end
                    period_cnt_d = '0;
                    high_cnt_d   = CNT_W'(pwm_s);
                end else if (period_cnt_q >= TIMEOUT_LAST) begin
                    strobe       = 1'b1;
                    new_code     = {PWM_CODE_W{pwm_s}};
                    locked_d     = 1'b0;
                    period_cnt_d = '0;
                    high_cnt_d   = CNT_W'(pwm_s);
                end else begin
                    period_cnt_d = sat_inc(period_cnt_q);
                    high_cnt_d   = pwm_s ? sat_inc(high_cnt_q) : high_cnt_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef AVG_EN
    logic [2:0][PWM_CODE_W-1:0] hist_q, hist_d;
    logic [PWM_CODE_W+1:0]      avg_sum;

    always_comb begin
        avg_sum = {2'b00, new_code} + {2'b00, hist_q[0]} + {2'b00, hist_q[1]} + {2'b00, hist_q[2]};
        hist_d  = hist_q;
        if (strobe) begin
            hist_d = {hist_q[1], hist_q[0], new_code};
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) hist_q <= '0;
        else      hist_q <= hist_d;
    end

    assign out_code = avg_sum[PWM_CODE_W+1:2];
`else
    assign out_code = new_code;
`endif

    always_comb begin
        duty_d  = strobe ? out_code : duty_q;
        valid_d = strobe;
    end

    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            period_cnt_q <= '0;
            high_cnt_q   <= '0;
            duty_q       <= '0;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            period_cnt_q <= period_cnt_d;
            high_cnt_q   <= high_cnt_d;
            duty_q       <= duty_d;
            valid_q      <= valid_d;
            err_q        <= err_d;
            locked_q     <= locked_d;
        end
    end

    assign dec.duty_out   = duty_q;
    assign dec.duty_valid = valid_q;
    assign dec.period_err = err_q;
    assign dec.locked     = locked_q;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Directed bench for pwm_duty_decoder: frame-level model compared every cycle plus literal checkpoints.
module tb_pwm_duty_decoder;

    localparam int P = 256;
    localparam int T = 4;
    localparam int S = 2;

    logic CLOCK_50 = 1'b0;
    logic rst      = 1'b0;
    logic pwm_in   = 1'b0;

    pwm_duty_decoder_if dec();

    pwm_duty_decoder #(.PERIOD(P), .TOL(T), .SYNC_STAGES(S)) dut (
        .CLOCK_50 (CLOCK_50),
        .rst      (rst),
        .pwm_in   (pwm_in),
        .dec      (dec)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int checks = 0;
    int errors = 0;
    int nstb   = 0;

    // Frame-level model: remembers the synchronised waveform cycle by cycle and
    // derives each frame's length and high time from the rise positions.
    logic [7:0] m_duty   = '0;
    logic       m_valid  = 1'b0;
    logic       m_err    = 1'b0;
    logic       m_locked = 1'b0;
    bit         smp [0:S];
    bit         psh [0:65535];
    bit         armed = 1'b0;
    int         fs = 0;
    int         e  = 0;
    int         hist [0:2];

    function automatic int highs(input int from, input int upto);
        int n = 0;
        for (int i = from; i < upto; i++) n += int'(psh[i]);
        return n;
    endfunction

    always @(posedge CLOCK_50 or negedge rst) begin : model
        bit ps, rs, stb;
        int len, code;
        if (!rst) begin
            m_duty   <= '0;
            m_valid  <= 1'b0;
            m_err    <= 1'b0;
            m_locked <= 1'b0;
            armed    <= 1'b0;
            fs       <= 0;
            e        <= 0;
            for (int k = 0; k <= S; k++) smp[k] <= 1'b0;
            for (int k = 0; k < 3; k++) hist[k] <= 0;
        end else begin
            ps   = smp[S-1];
            rs   = ps && !smp[S];
            stb  = 1'b0;
            code = 0;
            psh[e] <= ps;
            if (!armed) begin
                if (rs) begin
                    armed <= 1'b1;
                    fs    <= e;
                end
            end else if (rs) begin
                len = e - fs;
                if (len >= P - T && len <= P + T) begin
                    stb  = 1'b1;
                    code = highs(fs, e);
                    if (code > 255) code = 255;
                    m_locked <= 1'b1;
                    m_err    <= 1'b0;
                end else begin
                    m_err <= 1'b1;
                end
                fs <= e;
            end else if (e - fs == P + T) begin
                stb  = 1'b1;
                code = ps ? 255 : 0;
                m_locked <= 1'b0;
                fs <= e;
            end
            m_valid <= stb;
            if (stb) begin
`ifdef AVG_EN
                m_duty  <= 8'((code + hist[0] + hist[1] + hist[2]) / 4);
                hist[0] <= code;
                hist[1] <= hist[0];
                hist[2] <= hist[1];
`else
                m_duty  <= 8'(code);
`endif
            end
            for (int k = S; k > 0; k--) smp[k] <= smp[k-1];
            smp[0] <= pwm_in;
            e <= e + 1;
        end
    end

    always @(negedge CLOCK_50) begin : compare
        checks++;
        if ({dec.duty_out, dec.duty_valid, dec.period_err, dec.locked} !==
            {m_duty, m_valid, m_err, m_locked}) begin
            errors++;
            $display("FAIL model_cmp t=%0t got duty=%h vld=%b err=%b lck=%b, want duty=%h vld=%b err=%b lck=%b",
                     $time, dec.duty_out, dec.duty_valid, dec.period_err, dec.locked,
                     m_duty, m_valid, m_err, m_locked);
        end
        if (dec.duty_valid === 1'b1) nstb++;
    end

    task automatic lit(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic frame(input int len, input int high);
        for (int i = 0; i < len; i++) begin
            @(negedge CLOCK_50);
            pwm_in = (i < high);
        end
    endtask

    task automatic hold(input bit v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLOCK_50);
            pwm_in = v;
        end
    endtask

    int s0;

    initial begin
        // Reset state
        repeat (3) @(negedge CLOCK_50);
        #1;
        lit("rst_duty",   32'(dec.duty_out),   32'h00);
        lit("rst_valid",  32'(dec.duty_valid), 32'h0);
        lit("rst_err",    32'(dec.period_err), 32'h0);
        lit("rst_locked", 32'(dec.locked),     32'h0);
        #1 rst = 1'b1;

        // Steady 0x40 frames: first rise only arms, the next three close frames
        s0 = nstb;
        repeat (4) frame(256, 64);
        #1;
        lit("t1_strobes", 32'(nstb - s0), 32'd3);
`ifndef AVG_EN
        lit("t1_duty", 32'(dec.duty_out), 32'h40);
`endif
        lit("t1_locked", 32'(dec.locked),     32'h1);
        lit("t1_err",    32'(dec.period_err), 32'h0);

        // Dead-low then stuck-high link
        s0 = nstb;
        hold(1'b0, 200);
        #1;
        lit("t2_lo_strobes", 32'(nstb - s0), 32'd1);
`ifndef AVG_EN
        lit("t2_lo_duty", 32'(dec.duty_out), 32'h00);
`endif
        lit("t2_lo_locked", 32'(dec.locked), 32'h0);
        s0 = nstb;
        hold(1'b1, 300);
        #1;
        lit("t2_hi_strobes", 32'(nstb - s0), 32'd1);
`ifndef AVG_EN
        lit("t2_hi_duty", 32'(dec.duty_out), 32'hFF);
`endif
        lit("t2_hi_locked", 32'(dec.locked),     32'h0);
        lit("t2_hi_err",    32'(dec.period_err), 32'h1);

        // Over-long frames flag period_err; a good 0x80 frame clears it
        hold(1'b0, 10);
        repeat (3) frame(300, 150);
        #1;
        lit("t3_err", 32'(dec.period_err), 32'h1);
        repeat (2) frame(256, 128);
        #1;
`ifndef AVG_EN
        lit("t3_duty", 32'(dec.duty_out), 32'h80);
`endif
        lit("t3_err_clr", 32'(dec.period_err), 32'h0);
        lit("t3_locked",  32'(dec.locked),     32'h1);

        // Reset in the middle of a frame
        frame(100, 64);
        #2 rst = 1'b0;
        repeat (5) @(negedge CLOCK_50);
        #1;
        lit("t4_rst_duty",   32'(dec.duty_out), 32'h00);
        lit("t4_rst_locked", 32'(dec.locked),   32'h0);
        #1 rst = 1'b1;
        s0 = nstb;
        frame(256, 200);
        #1;
        lit("t4_arm_only", 32'(nstb - s0), 32'd0);
        frame(256, 200);
        #1;
        lit("t4_strobes", 32'(nstb - s0), 32'd1);
`ifndef AVG_EN
        lit("t4_duty", 32'(dec.duty_out), 32'hC8);
`endif
        lit("t4_locked", 32'(dec.locked), 32'h1);

        // Full-scale, tolerance-edge and zero codes
        repeat (2) frame(256, 255);
        #1;
`ifndef AVG_EN
        lit("t5_ff", 32'(dec.duty_out), 32'hFF);
`endif
        lit("t5_ff_err", 32'(dec.period_err), 32'h0);
        frame(259, 100);
        frame(256, 50);
        #1;
`ifndef AVG_EN
        lit("t5_259_duty", 32'(dec.duty_out), 32'h64);
`endif
        lit("t5_259_err",    32'(dec.period_err), 32'h0);
        lit("t5_259_locked", 32'(dec.locked),     32'h1);
        repeat (2) frame(256, 0);
        #1;
`ifndef AVG_EN
        lit("t5_zero_duty", 32'(dec.duty_out), 32'h00);
`endif
        lit("t5_zero_err", 32'(dec.period_err), 32'h0);

`ifdef AVG_EN
        // Alternating 0x40/0x80 averaged from a cleared history
        @(negedge CLOCK_50);
        #2 rst = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        #2 rst = 1'b1;
        s0 = nstb;
        frame(256, 64);
        frame(256, 128);
        frame(256, 64);
        frame(256, 128);
        frame(256, 64);
        #1;
        lit("t6_strobes", 32'(nstb - s0), 32'd4);
        lit("t6_avg",     32'(dec.duty_out), 32'h60);
`endif

        repeat (4) @(negedge CLOCK_50);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
